// File: rtl/vm1_bus_pkg.sv
// Shared constants, FSM encoding and helpers for the 1801VM1 bus responder.
package vm1_bus_pkg;

    // On-chip system register addresses (word aligned)
    localparam logic [15:0] ADDR_SEL1          = 16'o177716;
    localparam logic [15:0] ADDR_SEL2          = 16'o177714;
    localparam logic [15:0] DEF_IO_BASE        = 16'o177600;
    localparam int          DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_REG,
        ST_REPLY,
        ST_HOLD
    } state_t;

    // Byte writes select one lane from addr[0]; everything else is a full word
    function automatic logic [1:0] byte_en(input logic wr, input logic wtbt, input logic a0);
        if (wr && wtbt) return a0 ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    // Replace only the enabled byte lanes of a register value
    function automatic logic [15:0] merge_lanes(input logic [15:0] old, input logic [15:0] wd,
                                                input logic [1:0] be);
        return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    endfunction

endpackage

// File: rtl/vm1_bus_responder_bus_timeout_ctr.sv
// Saturating access-timeout counter: clear at acceptance, count while enabled,
// single expiry pulse on the ce cycle that reaches LIMIT.
module bus_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, then increment until pinned at LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != LIM)
            cnt_d = cnt_q + 1'b1;
    end

    // Fires only on the transition into LIMIT, so a pinned counter stays quiet
    assign expire = ce && en && !clr && (cnt_q == LIM - 1'b1);

    // Count register, frozen while ce is low
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (ce)
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vm1_bus_responder.sv
// Bus-side slave stage for the 1801VM1 core: memory port with wait states,
// system registers 177714/177716, protocol and timeout bus errors.
// Optional timeout: define VM1_BUS_TIMEOUT_EN.
module vm1_bus_responder
    import vm1_bus_pkg::*;
#(
    parameter logic [15:0] IO_BASE        = DEF_IO_BASE,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [15:0] SEL1_RESET     = 16'o000000,
    parameter logic [15:0] SEL2_RESET     = 16'o000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdat_i,
    input  logic        din,
    input  logic        dout,
    input  logic        wtbt,
    output logic        rply,
    output logic [15:0] rdat_o,
    output logic        berr,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] sel1_q,
    input  logic [15:0] sel1_d,
    output logic [15:0] sel2_q,
    input  logic [15:0] sel2_d
);
    state_t      state_q, state_d;
    logic        rply_q, rply_d, berr_q, berr_d;
    logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [15:0] rdat_q, rdat_d, wdat_q, wdat_d;
    logic [14:0] addr_q, addr_d;
    logic [1:0]  be_q, be_d;
    logic        wr_q, wr_d, unmap_q, unmap_d, abort_q, abort_d;
    logic [15:0] sel1_lat_q, sel1_lat_d, sel2_lat_q, sel2_lat_d;
    logic        accept, idle_bus, dropped, expire;

    assign accept   = (state_q == ST_IDLE) && (din ^ dout);
    assign idle_bus = !din && !dout;
    assign dropped  = abort_q || idle_bus;

`ifdef VM1_BUS_TIMEOUT_EN
    bus_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .clr    (accept),
        .en     (state_q == ST_MEM),
        .expire (expire)
    );
`else
    // Timeout disabled: expiry can never fire for any legal limit
    assign expire = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and registered-output logic for the bus FSM
    always_comb begin
        state_d    = state_q;
        rply_d     = rply_q;
        berr_d     = 1'b0;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        rdat_d     = rdat_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        be_d       = be_q;
        wr_d       = wr_q;
        unmap_d    = unmap_q;
        abort_d    = abort_q;
        sel1_lat_d = sel1_lat_q;
        sel2_lat_d = sel2_lat_q;
        case (state_q)
            ST_IDLE: begin
                if (din && dout) begin
                    berr_d  = 1'b1;
                    state_d = ST_HOLD;
                end else if (din ^ dout) begin
                    addr_d  = addr_i[15:1];
                    wdat_d  = wdat_i;
                    wr_d    = dout;
                    be_d    = byte_en(dout, wtbt, addr_i[0]);
                    abort_d = 1'b0;
                    unmap_d = 1'b0;
                    if (addr_i < IO_BASE) begin
                        state_d  = ST_MEM;
                        mem_rd_d = din;
                        mem_wr_d = dout;
                    end else if (addr_i[15:1] == ADDR_SEL1[15:1] ||
                                 addr_i[15:1] == ADDR_SEL2[15:1]) begin
                        state_d = ST_REG;
                    end else begin
                        unmap_d = 1'b1;
`ifdef VM1_BUS_TIMEOUT_EN
                        state_d = ST_MEM;   // silent wait, no request; ends in timeout
`else
                        state_d = ST_REG;   // immediate reply, reads 0, writes dropped
`endif
                    end
                end
            end
            ST_MEM: begin
                if (idle_bus) abort_d = 1'b1;
                if (mem_ack && !unmap_q) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (!wr_q) rdat_d = mem_rdata;
                    if (dropped) begin
                        state_d = ST_IDLE;
                    end else begin
                        rply_d  = 1'b1;
                        state_d = ST_REPLY;
                    end
                end else if (expire) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (dropped) begin
                        state_d = ST_IDLE;
                    end else begin
                        berr_d  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_REG: begin
                rply_d  = 1'b1;
                state_d = ST_REPLY;
                if (wr_q) begin
                    if (!unmap_q && addr_q == ADDR_SEL1[15:1])
                        sel1_lat_d = merge_lanes(sel1_lat_q, wdat_q, be_q);
                    else if (!unmap_q)
                        sel2_lat_d = merge_lanes(sel2_lat_q, wdat_q, be_q);
                end else begin
                    if (unmap_q)
                        rdat_d = 16'o000000;
                    else if (addr_q == ADDR_SEL1[15:1])
                        rdat_d = sel1_d;
                    else
                        rdat_d = sel2_d;
                end
            end
            ST_REPLY: begin
                if (idle_bus) begin
                    rply_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (idle_bus) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset overrides ce, ce=0 freezes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rply_q     <= 1'b0;
            berr_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            rdat_q     <= '0;
            addr_q     <= '0;
            wdat_q     <= '0;
            be_q       <= '0;
            wr_q       <= 1'b0;
            unmap_q    <= 1'b0;
            abort_q    <= 1'b0;
            sel1_lat_q <= SEL1_RESET;
            sel2_lat_q <= SEL2_RESET;
        end else if (ce) begin
            state_q    <= state_d;
            rply_q     <= rply_d;
            berr_q     <= berr_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            rdat_q     <= rdat_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            unmap_q    <= unmap_d;
            abort_q    <= abort_d;
            sel1_lat_q <= sel1_lat_d;
            sel2_lat_q <= sel2_lat_d;
        end
    end

    assign rply      = rply_q;
    assign berr      = berr_q;
    assign rdat_o    = rdat_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdat_q;
    assign mem_be    = be_q;
    assign sel1_q    = sel1_lat_q;
    assign sel2_q    = sel2_lat_q;
endmodule

// File: tb/tb_vm1_bus_responder.sv
// Directed bench for vm1_bus_responder: cycle table plus hand-written corner sequences.
module tb_vm1_bus_responder;
    logic        clk = 1'b0;
    logic        reset, ce, din, dout, wtbt, mem_ack;
    logic [15:0] addr_i, wdat_i, mem_rdata, sel1_d, sel2_d;
    logic        rply, berr, mem_rd, mem_wr;
    logic [15:0] rdat_o, mem_wdata, sel1_q, sel2_q;
    logic [14:0] mem_addr;
    logic [1:0]  mem_be;

    vm1_bus_responder dut (
        .clk(clk), .reset(reset), .ce(ce), .addr_i(addr_i), .wdat_i(wdat_i),
        .din(din), .dout(dout), .wtbt(wtbt), .rply(rply), .rdat_o(rdat_o), .berr(berr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sel1_q(sel1_q), .sel1_d(sel1_d), .sel2_q(sel2_q), .sel2_d(sel2_d)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, din, dout, wtbt, ack;
        logic [15:0] addr, wdat;
        logic        rply, berr, rd, wr;
        logic [15:0] rdat, sel2;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t v(input logic rst, input logic di, input logic dw, input logic bt,
                               input logic ak, input logic [15:0] a, input logic [15:0] w,
                               input logic rp, input logic be, input logic rd, input logic wr,
                               input logic [15:0] rdat, input logic [15:0] s2);
        vec_t r;
        r.rst = rst; r.din = di; r.dout = dw; r.wtbt = bt; r.ack = ak;
        r.addr = a; r.wdat = w; r.rply = rp; r.berr = be; r.rd = rd; r.wr = wr;
        r.rdat = rdat; r.sel2 = s2;
        return r;
    endfunction

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            reset = tbl[i].rst; din = tbl[i].din; dout = tbl[i].dout; wtbt = tbl[i].wtbt;
            mem_ack = tbl[i].ack; addr_i = tbl[i].addr; wdat_i = tbl[i].wdat;
            step();
            chk($sformatf("row%0d.rply", i), rply, tbl[i].rply);
            chk($sformatf("row%0d.berr", i), berr, tbl[i].berr);
            chk($sformatf("row%0d.mem_rd", i), mem_rd, tbl[i].rd);
            chk($sformatf("row%0d.mem_wr", i), mem_wr, tbl[i].wr);
            chk($sformatf("row%0d.rdat", i), rdat_o, tbl[i].rdat);
            chk($sformatf("row%0d.sel2", i), sel2_q, tbl[i].sel2);
        end
    endtask

    initial begin
        int bad;
        reset = 1'b1; ce = 1'b1; din = 1'b0; dout = 1'b0; wtbt = 1'b0; mem_ack = 1'b0;
        addr_i = '0; wdat_i = '0;
        mem_rdata = 16'o123456; sel1_d = 16'o100200; sel2_d = 16'o054321;

        //        rst di dw bt ak addr        wdat          rp be rd wr rdat        sel2
        tbl[0]  = v(1, 0, 0, 0, 0, 16'o000000, 16'h0000,    0, 0, 0, 0, 16'o000000, 16'h0000);
        // word write A5C3 to 177714
        tbl[1]  = v(0, 0, 1, 0, 0, 16'o177714, 16'hA5C3,    0, 0, 0, 0, 16'o000000, 16'h0000);
        tbl[2]  = v(0, 0, 1, 0, 0, 16'o177714, 16'hA5C3,    1, 0, 0, 0, 16'o000000, 16'hA5C3);
        tbl[3]  = v(0, 0, 0, 0, 0, 16'o177714, 16'hA5C3,    0, 0, 0, 0, 16'o000000, 16'hA5C3);
        // byte write 000377 to 177715: high lane only
        tbl[4]  = v(0, 0, 1, 1, 0, 16'o177715, 16'o000377,  0, 0, 0, 0, 16'o000000, 16'hA5C3);
        tbl[5]  = v(0, 0, 1, 1, 0, 16'o177715, 16'o000377,  1, 0, 0, 0, 16'o000000, 16'h00C3);
        tbl[6]  = v(0, 0, 1, 1, 0, 16'o177715, 16'o000377,  1, 0, 0, 0, 16'o000000, 16'h00C3);
        tbl[7]  = v(0, 0, 0, 0, 0, 16'o177715, 16'o000377,  0, 0, 0, 0, 16'o000000, 16'h00C3);
        // read 177716
        tbl[8]  = v(0, 1, 0, 0, 0, 16'o177716, 16'h0000,    0, 0, 0, 0, 16'o000000, 16'h00C3);
        tbl[9]  = v(0, 1, 0, 0, 0, 16'o177716, 16'h0000,    1, 0, 0, 0, 16'o100200, 16'h00C3);
        tbl[10] = v(0, 0, 0, 0, 0, 16'o177716, 16'h0000,    0, 0, 0, 0, 16'o100200, 16'h00C3);
        // memory word read at 001000, ack in the 3rd cycle of mem_rd
        tbl[11] = v(0, 1, 0, 0, 0, 16'o001000, 16'h0000,    0, 0, 1, 0, 16'o100200, 16'h00C3);
        tbl[12] = v(0, 1, 0, 0, 0, 16'o001000, 16'h0000,    0, 0, 1, 0, 16'o100200, 16'h00C3);
        tbl[13] = v(0, 1, 0, 0, 0, 16'o001000, 16'h0000,    0, 0, 1, 0, 16'o100200, 16'h00C3);
        tbl[14] = v(0, 1, 0, 0, 1, 16'o001000, 16'h0000,    1, 0, 0, 0, 16'o123456, 16'h00C3);
        tbl[15] = v(0, 1, 0, 0, 0, 16'o001000, 16'h0000,    1, 0, 0, 0, 16'o123456, 16'h00C3);
        tbl[16] = v(0, 0, 0, 0, 0, 16'o001000, 16'h0000,    0, 0, 0, 0, 16'o123456, 16'h00C3);
        // din and dout together: berr pulse, hold, back to idle
        tbl[17] = v(0, 1, 1, 0, 0, 16'o001000, 16'h0000,    0, 1, 0, 0, 16'o123456, 16'h00C3);
        tbl[18] = v(0, 1, 1, 0, 0, 16'o001000, 16'h0000,    0, 0, 0, 0, 16'o123456, 16'h00C3);
        tbl[19] = v(0, 0, 0, 0, 0, 16'o001000, 16'h0000,    0, 0, 0, 0, 16'o123456, 16'h00C3);
        tbl[20] = v(0, 1, 0, 0, 0, 16'o177716, 16'h0000,    0, 0, 0, 0, 16'o123456, 16'h00C3);
        tbl[21] = v(0, 1, 0, 0, 0, 16'o177716, 16'h0000,    1, 0, 0, 0, 16'o100200, 16'h00C3);
        tbl[22] = v(0, 0, 0, 0, 0, 16'o177716, 16'h0000,    0, 0, 0, 0, 16'o100200, 16'h00C3);

        run_rows(0, 0);
        chk("reset.sel1", sel1_q, 16'o000000);
        run_rows(1, 11);
        chk("rd.mem_addr", mem_addr, 15'o000400);
        chk("rd.mem_be", mem_be, 2'b11);
        run_rows(12, 22);

        // memory byte write to odd address 001001
        dout = 1'b1; wtbt = 1'b1; addr_i = 16'o001001; wdat_i = 16'h1200;
        step();
        chk("bw.mem_wr", mem_wr, 1'b1);
        chk("bw.mem_rd", mem_rd, 1'b0);
        chk("bw.mem_be", mem_be, 2'b10);
        chk("bw.mem_addr", mem_addr, 15'o000400);
        chk("bw.mem_wdata", mem_wdata, 16'h1200);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("bw.rply", rply, 1'b1);
        chk("bw.wr_drop", mem_wr, 1'b0);
        dout = 1'b0; wtbt = 1'b0;
        step();
        chk("bw.rply_rel", rply, 1'b0);

        // strobe dropped while memory is busy: request kept, no reply on ack
        din = 1'b1; addr_i = 16'o002000;
        step();
        chk("ab.mem_rd", mem_rd, 1'b1);
        chk("ab.mem_addr", mem_addr, 15'o001000);
        din = 1'b0;
        step();
        chk("ab.req_kept", mem_rd, 1'b1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("ab.rd_drop", mem_rd, 1'b0);
        chk("ab.no_rply", rply, 1'b0);
        chk("ab.no_berr", berr, 1'b0);
        step();
        chk("ab.no_rply2", rply, 1'b0);
        din = 1'b1; addr_i = 16'o177716;
        step();
        step();
        chk("ab.idle_again", rply, 1'b1);
        din = 1'b0;
        step();

        // unmapped I/O read at 177600
        din = 1'b1; addr_i = 16'o177600;
        step();
        chk("um.no_req", mem_rd, 1'b0);
`ifdef VM1_BUS_TIMEOUT_EN
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            step();
            if (berr !== 1'b0 || rply !== 1'b0) bad++;
        end
        chk("to.early_cycles", bad, 0);
        step();
        chk("to.berr", berr, 1'b1);
        chk("to.no_rply", rply, 1'b0);
        step();
        chk("to.berr_pulse", berr, 1'b0);
        din = 1'b0;
        step();
        chk("to.quiet", berr | rply, 1'b0);
`else
        bad = 0;
        step();
        chk("um.rply", rply, 1'b1);
        chk("um.rdat", rdat_o, 16'o000000);
        chk("um.no_berr", berr, 1'b0);
        din = 1'b0;
        step();
        chk("um.rply_rel", rply, 1'b0);
`endif

        // reset while mem_rd pending; ce low freezes the FSM
        din = 1'b1; addr_i = 16'o001000;
        step();
        chk("rs.mem_rd", mem_rd, 1'b1);
        ce = 1'b0; mem_ack = 1'b1;
        step();
        step();
        chk("ce.frozen_rd", mem_rd, 1'b1);
        chk("ce.frozen_rply", rply, 1'b0);
        mem_ack = 1'b0; reset = 1'b1; din = 1'b0;
        step();
        chk("rs.rd_clear", mem_rd, 1'b0);
        chk("rs.rply", rply, 1'b0);
        chk("rs.sel2", sel2_q, 16'o000000);
        chk("rs.rdat", rdat_o, 16'o000000);
        reset = 1'b0; ce = 1'b1; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rs.late_ack_rply", rply, 1'b0);
        chk("rs.late_ack_rd", mem_rd, 1'b0);
        step();
        chk("rs.late_ack_rply2", rply, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vm1_bus_responder.md
Name: vm1_bus_responder

Overview:
- Bus-side slave stage directly downstream of the 1801VM1 CPU core.
- Consumes the CPU's DIN/DOUT/WTBT strobes, address and write data; produces RPLY, read data and bus-error back to the CPU.
- Routes accesses to a wait-stated word memory port or to the two on-chip system registers (177714, 177716).
- Flags unmapped I/O and stalled memory with a bus-timeout error.

Parameters:
- IO_BASE, 16'o177600: addresses >= this are I/O space; below is memory.
- TIMEOUT_CYCLES, 16: ce-qualified cycles from acceptance to bus error.
- SEL1_RESET, 16'o000000: reset value of the 177716 write latch.
- SEL2_RESET, 16'o000000: reset value of the 177714 write latch.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; state advances only when ce=1
- addr_i  in  16  CPU address
- wdat_i  in  16  CPU write data; byte already in its lane
- din  in  1  CPU read strobe
- dout  in  1  CPU write strobe
- wtbt  in  1  byte write qualifier
- rply  out  1  reply to CPU
- rdat_o  out  16  read data to CPU
- berr  out  1  bus error to CPU
- mem_addr  out  15  word address (addr_i[15:1])
- mem_wdata  out  16  write data
- mem_be  out  2  byte enables {hi,lo}
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  16  memory read data, valid with mem_ack
- sel1_q  out  16  177716 write latch
- sel1_d  in  16  177716 read value
- sel2_q  out  16  177714 write latch
- sel2_d  in  16  177714 read value

Behaviour:
- Reset (sync, overrides ce): FSM=IDLE. rply, berr, mem_rd, mem_wr = 0. rdat_o = 0. sel1_q = SEL1_RESET, sel2_q = SEL2_RESET.
- Reset mid-access drops mem_rd/mem_wr in the same edge; an in-flight mem_ack is ignored.
- ce=0: all state and outputs hold.
- FSM states: IDLE, MEM, REG, REPLY, HOLD.
- IDLE, exactly one of din/dout high: latch address, direction and byte enables; clear the timeout counter.
  - addr < IO_BASE -> MEM.
  - addr[15:1] matches 177714 or 177716 -> REG.
  - Any other I/O address -> counter runs in MEM-like wait with no request issued, ending in timeout.
- IDLE, din and dout both high: berr pulse for 1 cycle, then HOLD.
- Byte enables:
  - din, or dout with wtbt=0: mem_be = 2'b11.
  - dout with wtbt=1: mem_be = addr[0] ? 2'b10 : 2'b01.
  - Reads are always full word.
- REG:
  - Write updates only the enabled byte lanes of the target latch.
  - Read loads rdat_o from sel1_d or sel2_d.
  - Next state REPLY; rply is high exactly 1 cycle after the strobe is accepted.
- MEM:
  - mem_rd or mem_wr asserted from the cycle after acceptance; held until mem_ack.
  - On ack: rdat_o <= mem_rdata (reads), request drops, next state REPLY.
  - Latency: rply rises 1 cycle after mem_ack.
- REPLY: rply held high until both strobes are low; rply drops on that edge; next state IDLE.
- Timeout: counter increments each ce cycle in MEM and in unmapped wait. On reaching TIMEOUT_CYCLES:
  - berr pulses 1 cycle, no rply.
  - mem_rd/mem_wr drop.
  - Next state HOLD.
- HOLD: wait until both strobes are low, then IDLE.
- Strobe dropped early in MEM: the outstanding request is kept until mem_ack or timeout, then go to IDLE with no rply and no berr.
- Counter saturates; it never wraps.

Optional Feature:
- Macro: VM1_BUS_TIMEOUT_EN.
- Defined: timeout as described above.
- Undefined:
  - No counter; berr is raised only for the din&dout protocol error.
  - Unmapped I/O replies immediately with rdat_o = 0 and writes are discarded.
  - MEM waits indefinitely for mem_ack.

Decomposition:
- Package vm1_bus_pkg:
  - Octal address constants ADDR_SEL1 = 16'o177716, ADDR_SEL2 = 16'o177714, default IO_BASE.
  - FSM state encoding.
  - Default TIMEOUT_CYCLES.
- Sub-module bus_timeout_ctr: clear, enable, saturating count, expiry pulse; parameterised width and limit.

Test Plan:
- Word read at 001000, mem_ack 3 cycles after mem_rd -> mem_addr = 15'o000400, mem_be = 11; rply 1 cycle after ack; rdat_o = mem_rdata = 16'o123456.
- Byte write 16'o000377 to 177715 (wtbt=1) -> sel2_q[15:8] = 8'o000, low byte unchanged; rply high on the 2nd cycle after the dout edge.
- Read 177716 with sel1_d = 16'o100200 -> rdat_o = 16'o100200; rply released 1 cycle after din drops.
- Read unmapped 177600 (VM1_BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=16) -> berr 1-cycle pulse 16 cycles after acceptance; rply never asserted.
- din and dout both high -> berr pulse; no mem request; FSM returns to IDLE once both are low.
- reset while mem_rd is pending, with ce toggling -> outputs clear on the next clk edge; a late mem_ack produces no rply; state is frozen while ce=0.
